// File: rtl/dm_access_unit.sv
// Memory-access (M) and write-back (W) slice of the P6 MIPS core: registers E results,
// drives the byte-enable data-memory port, then extends load data for the GRF write-back.
module dm_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [31:0] e_pc,
    input  logic [3:0]  e_mem_op,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_store_data,
    input  logic        e_grf_we,
    input  logic [4:0]  e_grf_addr,
    input  logic [31:0] e_grf_wdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    input  logic [31:0] m_data_rdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        m_fwd_we,
    output logic [4:0]  m_fwd_addr,
    output logic [31:0] m_fwd_data,
    output logic        m_misalign,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_SH   = 4'd9;
    localparam logic [3:0] OP_SB   = 4'd10;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [15:0] half;
        logic [7:0]  byt;
        sh   = rdata >> {off, 3'b000};
        byt  = sh[7:0];
        half = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0000, half};
            OP_LB:   return {{24{byt[7]}}, byt};
            OP_LBU:  return {24'h000000, byt};
            default: return rdata;
        endcase
    endfunction

    logic        m_vld_q, m_vld_d;
    logic [31:0] m_pc_q, m_pc_d;
    logic [3:0]  m_op_q, m_op_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_sdata_q, m_sdata_d;
    logic        m_we_q, m_we_d;
    logic [4:0]  m_waddr_q, m_waddr_d;
    logic [31:0] m_wdata_q, m_wdata_d;

    logic        w_vld_q;
    logic [31:0] w_pc_q;
    logic [3:0]  w_op_q;
    logic [1:0]  w_off_q;
    logic        w_mis_q;
    logic        w_we_q;
    logic [4:0]  w_waddr_q;
    logic [31:0] w_wdata_q;
    logic [31:0] w_rdata_q;

    logic [1:0]  m_off;
    logic        m_mis;
    logic [3:0]  m_be;
    logic [31:0] m_lanes;

    // E -> M boundary: a bubble keeps the datapath fields but kills valid, op and write enable
    always_comb begin
        m_vld_d   = e_valid;
        m_pc_d    = e_pc;
        m_op_d    = e_valid ? e_mem_op : OP_NONE;
        m_addr_d  = e_addr;
        m_sdata_d = e_store_data;
        m_we_d    = e_valid & e_grf_we;
        m_waddr_d = e_grf_addr;
        m_wdata_d = e_grf_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_vld_q   <= 1'b0;
            m_pc_q    <= '0;
            m_op_q    <= OP_NONE;
            m_addr_q  <= '0;
            m_sdata_q <= '0;
            m_we_q    <= 1'b0;
            m_waddr_q <= '0;
            m_wdata_q <= '0;
        end else begin
            m_vld_q   <= m_vld_d;
            m_pc_q    <= m_pc_d;
            m_op_q    <= m_op_d;
            m_addr_q  <= m_addr_d;
            m_sdata_q <= m_sdata_d;
            m_we_q    <= m_we_d;
            m_waddr_q <= m_waddr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_off = m_addr_q[1:0];

    always_comb begin
        m_mis   = 1'b0;
        m_be    = 4'b0000;
        m_lanes = m_sdata_q;
        case (m_op_q)
            OP_LW:         m_mis = (m_off != 2'b00);
            OP_LH, OP_LHU: m_mis = m_off[0];
            OP_SW: begin
                m_mis = (m_off != 2'b00);
                m_be  = 4'b1111;
            end
            OP_SH: begin
                m_mis   = m_off[0];
                m_be    = 4'b0011 << m_off;
                m_lanes = {2{m_sdata_q[15:0]}};
            end
            OP_SB: begin
                m_be    = 4'b0001 << m_off;
                m_lanes = {4{m_sdata_q[7:0]}};
            end
            default: ;
        endcase
    end

    // Strobes drop with reset itself so a store caught in M at the reset edge never commits
    assign m_data_addr   = m_addr_q;
    assign m_data_wdata  = m_lanes;
    assign m_data_byteen = (m_vld_q && !m_mis && !reset) ? m_be : 4'b0000;
    assign m_inst_addr   = m_pc_q;
    assign m_misalign    = m_mis;
    assign m_fwd_we      = m_we_q & m_vld_q & ~is_load(m_op_q);
    assign m_fwd_addr    = m_waddr_q;
    assign m_fwd_data    = m_wdata_q;

    // M -> W boundary: read data is captured at the end of the M cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            w_vld_q   <= 1'b0;
            w_pc_q    <= '0;
            w_op_q    <= OP_NONE;
            w_off_q   <= '0;
            w_mis_q   <= 1'b0;
            w_we_q    <= 1'b0;
            w_waddr_q <= '0;
            w_wdata_q <= '0;
            w_rdata_q <= '0;
        end else begin
            w_vld_q   <= m_vld_q;
            w_pc_q    <= m_pc_q;
            w_op_q    <= m_op_q;
            w_off_q   <= m_off;
            w_mis_q   <= m_mis;
            w_we_q    <= m_we_q;
            w_waddr_q <= m_waddr_q;
            w_wdata_q <= m_wdata_q;
            w_rdata_q <= m_data_rdata;
        end
    end

    assign w_grf_we    = w_vld_q & w_we_q & ~(is_load(w_op_q) & w_mis_q);
    assign w_grf_addr  = w_waddr_q;
    assign w_grf_wdata = is_load(w_op_q) ? load_extract(w_op_q, w_off_q, w_rdata_q) : w_wdata_q;
    assign w_inst_addr = w_pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: a reference memory model predicts M and W outputs
// per issued instruction; a behavioural data memory is driven from the DUT's byte enables.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        e_valid = 1'b0;
    logic [31:0] e_pc = '0;
    logic [3:0]  e_mem_op = '0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_store_data = '0;
    logic        e_grf_we = 1'b0;
    logic [4:0]  e_grf_addr = '0;
    logic [31:0] e_grf_wdata = '0;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr, m_fwd_data;
    logic [3:0]  m_data_byteen;
    logic        m_fwd_we, m_misalign, w_grf_we;
    logic [4:0]  m_fwd_addr, w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr;

    dm_access_unit dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_pc(e_pc), .e_mem_op(e_mem_op),
        .e_addr(e_addr), .e_store_data(e_store_data), .e_grf_we(e_grf_we),
        .e_grf_addr(e_grf_addr), .e_grf_wdata(e_grf_wdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_rdata(m_data_rdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_fwd_we(m_fwd_we),
        .m_fwd_addr(m_fwd_addr), .m_fwd_data(m_fwd_data), .m_misalign(m_misalign),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr)
    );

    always #5 clk = ~clk;

    logic [31:0] mem  [0:63];
    logic [31:0] rmem [0:63];

    assign m_data_rdata = mem[m_data_addr[7:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) mem[m_data_addr[7:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
    end

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          e;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [3:0]  be;
        logic        is_st;
        logic [31:0] lanes;
        logic        mis;
        logic        fwe;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic        wwe;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t mq[$];
    exp_t wq[$];
    int   ecnt = 0;
    logic [31:0] pc_cnt = 32'h0000_3000;

    // Reference: predicts every M and W observable from op/address and the model memory
    task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic commit);
        exp_t x;
        logic [31:0] word;
        logic [1:0]  off;
        logic        ld;
        logic [31:0] lv;
        @(negedge clk);
        e_valid = v; e_mem_op = op; e_addr = a; e_store_data = sd;
        e_grf_we = we; e_grf_addr = wa; e_grf_wdata = wd; e_pc = pc_cnt;
        off  = a[1:0];
        word = rmem[a[7:2]];
        ld = 1'b0; lv = '0;
        x.e = ecnt + 1; x.addr = a; x.pc = pc_cnt;
        x.be = 4'b0000; x.is_st = 1'b0; x.lanes = '0; x.mis = 1'b0;
        if (v) begin
            case (op)
                4'd1: begin ld = 1; x.mis = (off != 0); lv = word; end
                4'd2: begin ld = 1; x.mis = off[0];
                            lv = off[1] ? {{16{word[31]}}, word[31:16]} : {{16{word[15]}}, word[15:0]}; end
                4'd3: begin ld = 1; x.mis = off[0];
                            lv = off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]}; end
                4'd4: begin ld = 1;
                            case (off)
                                2'd0: lv = {{24{word[7]}},  word[7:0]};
                                2'd1: lv = {{24{word[15]}}, word[15:8]};
                                2'd2: lv = {{24{word[23]}}, word[23:16]};
                                default: lv = {{24{word[31]}}, word[31:24]};
                            endcase end
                4'd5: begin ld = 1;
                            case (off)
                                2'd0: lv = {24'h0, word[7:0]};
                                2'd1: lv = {24'h0, word[15:8]};
                                2'd2: lv = {24'h0, word[23:16]};
                                default: lv = {24'h0, word[31:24]};
                            endcase end
                4'd8: begin x.is_st = 1; x.mis = (off != 0); x.lanes = sd;
                            if (!x.mis) begin x.be = 4'b1111; if (commit) rmem[a[7:2]] = sd; end end
                4'd9: begin x.is_st = 1; x.mis = off[0]; x.lanes = {sd[15:0], sd[15:0]};
                            if (!x.mis) begin
                                x.be = off[1] ? 4'b1100 : 4'b0011;
                                if (commit) rmem[a[7:2]][16*off[1] +: 16] = sd[15:0];
                            end end
                4'd10: begin x.is_st = 1; x.lanes = {4{sd[7:0]}};
                             case (off)
                                 2'd0: x.be = 4'b0001;
                                 2'd1: x.be = 4'b0010;
                                 2'd2: x.be = 4'b0100;
                                 default: x.be = 4'b1000;
                             endcase
                             if (commit) rmem[a[7:2]][8*off +: 8] = sd[7:0]; end
                default: ;
            endcase
        end
        x.fwe = v & we & ~ld;
        x.fa  = wa; x.fd = wd;
        x.wwe = v & we & ~(ld & x.mis);
        x.wa  = wa;
        x.wd  = ld ? lv : wd;
        mq.push_back(x);
        wq.push_back(x);
        pc_cnt = pc_cnt + 4;
    endtask

    task automatic bubble();
        issue(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always begin
        logic r;
        @(posedge clk);
        r = reset;
        #1;
        ecnt++;
        if (r) begin
            check_eq("rst_byteen", {28'h0, m_data_byteen}, 32'h0);
            check_eq("rst_m_addr", m_data_addr, 32'h0);
            check_eq("rst_m_wdata", m_data_wdata, 32'h0);
            check_eq("rst_m_pc", m_inst_addr, 32'h0);
            check_eq("rst_flags", {29'h0, m_fwd_we, m_misalign, w_grf_we}, 32'h0);
            check_eq("rst_w_pc", w_inst_addr, 32'h0);
            check_eq("rst_w_data", w_grf_wdata, 32'h0);
            check_eq("rst_w_addr", {27'h0, w_grf_addr}, 32'h0);
        end
        while (mq.size() > 0 && mq[0].e == ecnt) begin
            exp_t x;
            x = mq.pop_front();
            check_eq("m_byteen", {28'h0, m_data_byteen}, {28'h0, x.be});
            check_eq("m_addr", m_data_addr, x.addr);
            check_eq("m_pc", m_inst_addr, x.pc);
            check_eq("m_misalign", {31'h0, m_misalign}, {31'h0, x.mis});
            check_eq("m_fwd_we", {31'h0, m_fwd_we}, {31'h0, x.fwe});
            if (x.is_st) check_eq("m_wdata", m_data_wdata, x.lanes);
            if (x.fwe) begin
                check_eq("m_fwd_addr", {27'h0, m_fwd_addr}, {27'h0, x.fa});
                check_eq("m_fwd_data", m_fwd_data, x.fd);
            end
        end
        while (wq.size() > 0 && wq[0].e == ecnt - 1) begin
            exp_t x;
            x = wq.pop_front();
            check_eq("w_we", {31'h0, w_grf_we}, {31'h0, x.wwe});
            check_eq("w_pc", w_inst_addr, x.pc);
            if (x.wwe) begin
                check_eq("w_addr", {27'h0, w_grf_addr}, {27'h0, x.wa});
                check_eq("w_wdata", w_grf_wdata, x.wd);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 32'h0;
            rmem[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(1, 4'd8,  32'h10, 32'h12345678, 0, 5'd0,  32'h0, 1);   // sw
        issue(1, 4'd1,  32'h10, 32'h0,        1, 5'd8,  32'h0, 1);   // lw $8
        issue(1, 4'd10, 32'h13, 32'h000000AB, 0, 5'd0,  32'h0, 1);   // sb
        issue(1, 4'd4,  32'h13, 32'h0,        1, 5'd9,  32'h0, 1);   // lb
        issue(1, 4'd5,  32'h13, 32'h0,        1, 5'd10, 32'h0, 1);   // lbu
        issue(1, 4'd9,  32'h22, 32'h00008001, 0, 5'd0,  32'h0, 1);   // sh
        issue(1, 4'd2,  32'h22, 32'h0,        1, 5'd11, 32'h0, 1);   // lh
        issue(1, 4'd3,  32'h22, 32'h0,        1, 5'd12, 32'h0, 1);   // lhu
        issue(1, 4'd8,  32'h05, 32'h55555555, 0, 5'd0,  32'h0, 1);   // misaligned sw
        issue(1, 4'd1,  32'h06, 32'h0,        1, 5'd13, 32'h0, 1);   // misaligned lw
        issue(1, 4'd2,  32'h21, 32'h0,        1, 5'd14, 32'h0, 1);   // misaligned lh
        issue(1, 4'd9,  32'h23, 32'h0000BEEF, 0, 5'd0,  32'h0, 1);   // misaligned sh
        issue(1, 4'd10, 32'h20, 32'h00000080, 0, 5'd0,  32'h0, 1);   // sb lane 0
        issue(1, 4'd4,  32'h20, 32'h0,        1, 5'd15, 32'h0, 1);   // lb lane 0
        issue(1, 4'd4,  32'h21, 32'h0,        1, 5'd16, 32'h0, 1);   // lb lane 1
        issue(1, 4'd0,  32'h0,  32'h0,        1, 5'd3,  32'h7, 1);   // ALU $3 = 7
        issue(1, 4'd6,  32'h30, 32'hFFFFFFFF, 1, 5'd4,  32'h99, 1);  // unknown op -> none
        issue(0, 4'd8,  32'h30, 32'hFFFFFFFF, 1, 5'd5,  32'h11, 1);  // bubble carrying sw
        issue(1, 4'd1,  32'h30, 32'h0,        1, 5'd6,  32'h0, 1);   // lw sees untouched word
        issue(1, 4'd8,  32'h40, 32'hDEADBEEF, 0, 5'd0,  32'h0, 0);   // sw caught by reset
        for (int i = 0; i < 64; i++)
            if (i > 0 && rmem[i] === 32'hx) check_eq("model_init", rmem[i], 32'h0);

        // Reset lands while the sw is in M
        @(negedge clk);
        reset = 1'b1;
        e_valid = 1'b0; e_mem_op = 4'd0; e_grf_we = 1'b0;
        mq.delete();
        wq.delete();
        #1 check_eq("rst_comb_byteen", {28'h0, m_data_byteen}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mem_word", mem[16], 32'h0);

        issue(1, 4'd1, 32'h40, 32'h0, 1, 5'd7, 32'h0, 1);            // lw reads unchanged word
        issue(1, 4'd1, 32'h10, 32'h0, 1, 5'd8, 32'h0, 1);            // earlier sw survived
        repeat (3) bubble();
        repeat (2) @(negedge clk);
        check_eq("drain_queues", mq.size() + wq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Memory-access and write-back pipeline slice of the P6 MIPS core. It is the initiator side of the data-memory byte-enable interface. It registers E-stage results into an M register and drives `m_data_addr`, `m_data_wdata`, `m_data_byteen` and `m_inst_addr`. It captures `m_data_rdata` into a W register, sign- or zero-extends loads, and drives the `w_grf_*` / `w_inst_addr` write-back port that the testbench logs.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears the M and W registers.
- `e_valid`  in  1  E stage holds a real instruction; 0 inserts a bubble into M.
- `e_pc`  in  32  PC of the E-stage instruction.
- `e_mem_op`  in  4  memory operation:
  - 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 8 sw, 9 sh, 10 sb.
  - Any other code is treated as none.
- `e_addr`  in  32  ALU-computed byte address.
- `e_store_data`  in  32  forwarded rt value; the low bytes are the store payload.
- `e_grf_we`  in  1  instruction writes the GRF.
- `e_grf_addr`  in  5  destination register.
- `e_grf_wdata`  in  32  result for non-load instructions.
- `m_data_addr`  out  32  byte address to data memory; equals the M-register address.
- `m_data_wdata`  out  32  store data shifted into its byte lanes.
- `m_data_rdata`  in  32  word read combinationally from memory at `m_data_addr`.
- `m_data_byteen`  out  4  per-lane write strobes; all zero means no write.
- `m_inst_addr`  out  32  PC of the instruction in M.
- `m_fwd_we`, `m_fwd_addr`, `m_fwd_data`  out  1/5/32  M-stage forwarding source.
  - `m_fwd_we` is 0 for loads.
- `m_misalign`  out  1  the M-stage access is misaligned.
- `w_grf_we`  out  1  GRF write enable.
- `w_grf_addr`  out  5  GRF write address.
- `w_grf_wdata`  out  32  GRF write data.
- `w_inst_addr`  out  32  PC of the instruction in W.

## Operation
- **M register** (loaded each edge): valid, pc, mem_op, addr, store_data, grf_we, grf_addr, grf_wdata.
  - When `e_valid`=0, it loads valid=0, mem_op=none, grf_we=0.
- **Offset:** off = addr[1:0].
- **Misalignment:**
  - lw/sw: off≠0.
  - lh/lhu/sh: off[0]=1.
  - Byte ops are never misaligned.
- **Byte enables** (only when valid and not misaligned):
  - sw → 4'b1111.
  - sh → 4'b0011<<off.
  - sb → 4'b0001<<off.
  - Otherwise 0.
- **Store data lanes:**
  - sw → data.
  - sh → {2{data[15:0]}}.
  - sb → {4{data[7:0]}}.
- **Forwarding port:** `m_fwd_we` = grf_we & valid & (mem_op is not a load).
- **W register** (loaded each edge from M): valid, pc, mem_op, off, misalign, grf_we, grf_addr, grf_wdata, rdata = `m_data_rdata`.
- **Load extract** in W (combinational):
  - lw → rdata.
  - lh/lhu → half at rdata[16*off[1]+:16], sign- or zero-extended.
  - lb/lbu → byte at rdata[8*off+:8], sign- or zero-extended.
- **Write-back:**
  - `w_grf_wdata` = extracted value for loads, otherwise grf_wdata.
  - `w_grf_we` = valid & grf_we & !(load & misalign).
  - Register 0 is not filtered here.
- A misaligned store produces byteen 0. A misaligned load writes nothing. No other side effect in either case.

## Timing
- **Reset values:** all outputs 0 the cycle after `reset` is sampled high, including `m_data_byteen`=0, `w_grf_we`=0, `m_inst_addr`=0 and `w_inst_addr`=0.
- **Stage latency:** E inputs appear on the M outputs 1 cycle after the edge that samples them, and on the W outputs after 2 cycles.
- **Store:** commits at the edge that ends its M cycle; byteen is asserted for exactly one cycle per store.
- **Read path:** `m_data_rdata` must be valid in the same cycle as `m_data_addr`; it is sampled at the end of that cycle.
- **Back-to-back sw then lw to the same word:** the lw (in M one cycle later) reads the stored value. No hazard logic inside the block.
- **Reset asserted mid-operation:** the in-flight M and W contents are discarded. A store in M at the reset edge must not commit.
- **No stall input:** every instruction advances one stage per cycle.

## Test plan
- **sw, then lw:** `e_store_data`=0x12345678 at addr 0x10, then lw $8 from 0x10 → byteen 4'b1111 with wdata 0x12345678; two cycles later w_grf_addr=8, w_grf_wdata=0x12345678.
- **sb then lb/lbu:** sb 0xAB at 0x13 → byteen 4'b1000, wdata 0xABABABAB. lb from 0x13 → 0xFFFFFFAB; lbu from 0x13 → 0x000000AB.
- **sh then lh/lhu:** sh 0x8001 at 0x22 → byteen 4'b1100, wdata 0x80018001. lh from 0x22 → 0xFFFF8001; lhu from 0x22 → 0x00008001.
- **Misaligned:** sw at 0x05 → byteen 0 and m_misalign=1. lw at 0x06 → w_grf_we=0.
- **Non-load ALU op:** e_grf_wdata=0x7 to $3 → m_fwd_we=1 in M; w_grf_wdata=7 in W; byteen stays 0.
- **Reset with sw in M:** assert reset → byteen 0 next cycle and memory unchanged; all outputs 0 while reset is held.
